multicycle_ctrl: RTL and testbench

Main control FSM for the KLP32 multi-cycle RV32I datapath. Sequences instruction fetch, decode, execute, memory and writeback over several cycles, and drives the immediate generator select, ALU operand/op selects, register-file and memory enables and PC/IR write strobes. A `mem_ready` handshake stretches memory states for a shared instruction/data memory. Sits between the IR opcode fields and every datapath mux.

---
 rtl/multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the KLP32 multi-cycle RV32I datapath.
//
// Runs each instruction through fetch, decode, execute, memory and writeback over several
// cycles. Every datapath select, enable and strobe is decoded from the current state.
// A mem_ready handshake stretches FETCH, MEMREAD and MEMWRITE so that one instruction/data
// memory can be shared.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset; while high, all outputs are forced to 0
//   op          in   instr[6:0] from IR
//   funct3      in   instr[14:12] from IR
//   zero        in   ALU result == 0
//   lt / ltu    in   signed / unsigned rs1 < rs2
//   mem_ready   in   memory access completes this cycle
//   imm_sel     out  000 I, 001 S, 010 B, 011 U, 100 J
//   pc_write    out  PC load strobe
//   ir_write    out  IR and oldPC load strobe
//   adr_src     out  memory address: 0 PC, 1 ALUOut
//   mem_write   out  memory write request
//   reg_write   out  register-file write enable
//   alu_src_a   out  00 PC, 01 oldPC, 10 rs1, 11 zero
//   alu_src_b   out  00 rs2, 01 imm, 10 const 4
//   result_src  out  00 ALUOut, 01 memory data, 10 ALU result
//   alu_op      out  00 add, 01 compare/sub, 10 funct-decoded
//   illegal     out  sticky trap indicator (held until rst)
//
// Configuration macro: MC_BRANCH_FULL_EN
//   When defined, branches also decode funct3 100 (lt), 101 (~lt), 110 (ltu) and 111 (~ltu).
//   When undefined, only BEQ/BNE are legal; any other branch funct3 traps in DECODE.
//   Branch funct3 010/011 trap in both builds.

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic [2:0] imm_sel,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StAluWb, StBranch, StJal, StJalr, StJalr2, StLui, StAuipc, StTrap
  } state_e;

  state_e state_q, state_d;

  logic branch_f3_ok;
  logic branch_taken;

  // Branch condition decode. Legality is checked in DECODE so BRANCH never sees a bad funct3.
`ifdef MC_BRANCH_FULL_EN
  always_comb begin
    branch_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = ~ltu;
      default: branch_taken = 1'b0;
    endcase
  end
`else
  logic unused_cmp;
  assign unused_cmp = lt ^ ltu;

  always_comb begin
    branch_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      default: branch_taken = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imm_sel    = ImmI;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        // PC + 4 computed on the ALU and written back directly alongside the IR load.
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        alu_op     = 2'b00;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculative oldPC + imm: branch target, or JAL target when op is JAL.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
        imm_sel   = (op == OpJal) ? ImmJ : ImmB;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = branch_f3_ok ? StBranch : StTrap;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
        imm_sel   = (op == OpStore) ? ImmS : ImmI;
        state_d   = (op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_sel   = ImmI;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StLui: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_sel   = ImmU;
        state_d   = StAluWb;
      end
      StAuipc: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_sel   = ImmU;
        state_d   = StAluWb;
      end
      StAluWb: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        // ALUOut still holds the target from DECODE while the ALU compares rs1/rs2.
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        pc_write   = branch_taken;
        state_d    = StFetch;
      end
      StJal: begin
        // PC <- ALUOut (target), ALU forms oldPC + 4 for the link write in ALUWB.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_write   = 1'b1;
        state_d    = StAluWb;
      end
      StJalr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_sel   = ImmI;
        state_d   = StJalr2;
      end
      StJalr2: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_write   = 1'b1;
        state_d    = StAluWb;
      end
      StTrap: begin
        illegal = 1'b1;
        state_d = StTrap;
      end
      default: state_d = StFetch;
    endcase

    // Reset kills every output in the same cycle, including a write already in flight.
    if (rst) begin
      imm_sel    = 3'b000;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_op     = 2'b00;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Inputs change on the falling edge and outputs are
// compared 1 time unit later, against hand-written per-state output vectors packed as
// {imm_sel, pc_write, ir_write, adr_src, mem_write, reg_write, a, b, result_src, alu_op,
// illegal}.

module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic [2:0] imm_sel;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .mem_ready  (mem_ready),
    .imm_sel    (imm_sel),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

  logic [16:0] obs;
  assign obs = {imm_sel, pc_write, ir_write, adr_src, mem_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, illegal};

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  //                                imm    pcw   irw   adr   mw    rw    a      b      rs     aop    ill
  localparam logic [16:0] E_ZERO  = '0;
  localparam logic [16:0] E_FETCH = {3'b000,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,2'b00,1'b0};
  localparam logic [16:0] E_FSTAL = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,2'b00,1'b0};
  localparam logic [16:0] E_DEC_B = {3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_DEC_J = {3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MADRS = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MADRI = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MRD   = {3'b000,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MWB   = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b01,2'b00,1'b0};
  localparam logic [16:0] E_MWR   = {3'b000,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_EXR   = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] E_EXI   = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b10,1'b0};
  localparam logic [16:0] E_LUI   = {3'b011,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_AUIPC = {3'b011,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_ALUWB = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_BR_T  = {3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b01,1'b0};
  localparam logic [16:0] E_BR_N  = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b01,1'b0};
  localparam logic [16:0] E_JAL   = {3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_JALR  = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_JALR2 = {3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_TRAP  = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs after the falling edge and let combinational outputs settle.
  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic z,
                       input logic l, input logic lu, input logic r);
    @(negedge clk);
    op = o; funct3 = f; zero = z; lt = l; ltu = lu; mem_ready = r;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1; op = OP_STORE; zero = 1'b1;
      #1;
      checks++;
      if (obs !== E_ZERO) begin
        errors++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, E_ZERO);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ADDI with mem_ready low outside FETCH: it must be ignored there.
  task automatic test_addi;
    logic [16:0] exp [4];
    logic        rdy [4];
    exp = '{E_FETCH, E_DEC_B, E_EXI, E_ALUWB};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(OP_IMM, 3'b000, 1'b0, 1'b0, 1'b0, rdy[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL addi cycle %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  // SW with three stall cycles in MEMWRITE, then a stalled FETCH.
  task automatic test_store_stall;
    logic [16:0] exp [8];
    logic        rdy [8];
    exp = '{E_FETCH, E_DEC_B, E_MADRS, E_MWR, E_MWR, E_MWR, E_MWR, E_FSTAL};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, rdy[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL store cycle %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  // LW with one stall in MEMREAD.
  task automatic test_load_stall;
    logic [16:0] exp [7];
    logic        rdy [7];
    exp = '{E_FETCH, E_DEC_B, E_MADRI, E_MRD, E_MRD, E_MWB, E_FSTAL};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, rdy[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL load cycle %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_alu_types;
    logic [6:0]  ops  [3];
    logic [16:0] mid  [3];
    logic [16:0] exp;
    ops = '{OP_REG, OP_LUI, OP_AUIPC};
    mid = '{E_EXR, E_LUI, E_AUIPC};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        exp = (i == 0) ? E_FETCH : (i == 1) ? E_DEC_B : (i == 2) ? mid[k] : E_ALUWB;
        drive(ops[k], 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL alu op %b cycle %0d: got %b want %b", ops[k], i, obs, exp);
        end
      end
    end
  endtask

  // BEQ/BNE with both zero values; three cycles each.
  task automatic test_branch;
    logic [2:0]  f3 [4];
    logic        zv [4];
    logic [16:0] br [4];
    logic [16:0] exp;
    f3 = '{3'b000, 3'b000, 3'b001, 3'b001};
    zv = '{1'b1, 1'b0, 1'b0, 1'b1};
    br = '{E_BR_T, E_BR_N, E_BR_T, E_BR_N};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        exp = (i == 0) ? E_FETCH : (i == 1) ? E_DEC_B : br[k];
        drive(OP_BRANCH, f3[k], zv[k], 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL branch f3=%b zero=%b cycle %0d: got %b want %b",
                   f3[k], zv[k], i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_jal_jalr;
    logic [16:0] ej [4];
    logic [16:0] er [6];
    ej = '{E_FETCH, E_DEC_J, E_JAL, E_ALUWB};
    er = '{E_FETCH, E_DEC_B, E_JALR, E_JALR2, E_ALUWB, E_FSTAL};
    for (int i = 0; i < 4; i++) begin
      drive(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== ej[i]) begin
        errors++;
        $display("FAIL jal cycle %0d: got %b want %b", i, obs, ej[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, (i == 5) ? 1'b0 : 1'b1);
      checks++;
      if (obs !== er[i]) begin
        errors++;
        $display("FAIL jalr cycle %0d: got %b want %b", i, obs, er[i]);
      end
    end
  endtask

  // Reset out of TRAP, then confirm FETCH (stalled so the state stays put).
  task automatic reset_from_trap(input string tag);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== E_ZERO) begin
      errors++;
      $display("FAIL %s rst-in-trap: got %b want %b", tag, obs, E_ZERO);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive(OP_IMM, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== E_FSTAL) begin
      errors++;
      $display("FAIL %s fetch-after-rst: got %b want %b", tag, obs, E_FSTAL);
    end
  endtask

  task automatic test_trap;
    logic [16:0] exp;
    for (int i = 0; i < 12; i++) begin
      exp = (i == 0) ? E_FETCH : (i == 1) ? E_DEC_B : E_TRAP;
      drive(7'b0000000, 3'b000, 1'b1, 1'b1, 1'b1, (i < 2) ? 1'b1 : i[0]);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL trap cycle %0d: got %b want %b", i, obs, exp);
      end
    end
    reset_from_trap("trap");
  endtask

  // funct3 010 always traps; BLT depends on the build.
  task automatic test_branch_full;
    logic [16:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = (i == 0) ? E_FETCH : (i == 1) ? E_DEC_B : E_TRAP;
      drive(OP_BRANCH, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL branch f3=010 cycle %0d: got %b want %b", i, obs, exp);
      end
    end
    reset_from_trap("br010");
    // State is FETCH here; a ready FETCH starts the BLT.
    for (int i = 0; i < 3; i++) begin
`ifdef MC_BRANCH_FULL_EN
      exp = (i == 0) ? E_FETCH : (i == 1) ? E_DEC_B : E_BR_T;
`else
      exp = (i == 0) ? E_FETCH : (i == 1) ? E_DEC_B : E_TRAP;
`endif
      drive(OP_BRANCH, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL blt cycle %0d: got %b want %b", i, obs, exp);
      end
    end
    reset_from_trap("blt");
  endtask

  initial begin
    rst = 1'b0; op = '0; funct3 = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_store_stall();
    test_load_stall();
    test_alu_types();
    test_branch();
    test_jal_jalr();
    test_trap();
    test_branch_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
